alaw_coder_pipe: RTL and testbench



---
 rtl/alaw_coder_pipe.sv | 129 ++++++++++++
 tb/tb_alaw_coder_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alaw_coder_pipe.sv
// Two-stage pipelined A-law compressor with valid/ready backpressure.
// Stage 1 forms sign/magnitude; stage 2 segment-encodes straight into the output registers.
module alaw_coder_pipe #(
  parameter int DATA_IN_W = 15,
  parameter int EXP_W     = 3,
  parameter int MANT_W    = 5,
  parameter int SIGNED    = 0,
  parameter logic [SIGNED+EXP_W+MANT_W-1:0] XOR_MASK = '0,
  parameter int TAG_W     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_IN_W+SIGNED-1:0]        data_in,
  input  logic [TAG_W-1:0]                   tag_in,
  input  logic                               valid_in,
  output logic                               ready_in,
  output logic [SIGNED+EXP_W+MANT_W-1:0]     data_out,
  output logic [TAG_W-1:0]                   tag_out,
  output logic                               valid_out,
  input  logic                               ready_out
);

  localparam int CODE_W = SIGNED + EXP_W + MANT_W;
  localparam int B      = DATA_IN_W - (1 << EXP_W);

  logic                 stall;
  logic                 in_sign;
  logic [DATA_IN_W-1:0] in_mag;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q, s1_sign_d;
  logic [DATA_IN_W-1:0] s1_mag_q, s1_mag_d;
  logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;

  logic                 valid_out_q, valid_out_d;
  logic [CODE_W-1:0]    data_out_q, data_out_d;
  logic [TAG_W-1:0]     tag_out_q, tag_out_d;

  logic [EXP_W-1:0]     seg_exp;
  logic [MANT_W-1:0]    seg_mant;
  logic [CODE_W-1:0]    code;

  assign stall     = valid_out_q & ~ready_out;
  assign ready_in  = ~stall;
  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign tag_out   = tag_out_q;

  // The most negative input has no positive twin, so it saturates to all ones.
  generate
    if (SIGNED != 0) begin : g_signed
      logic [DATA_IN_W:0] neg;
      always_comb begin
        in_sign = data_in[DATA_IN_W];
        neg     = -data_in;
        if (!in_sign)
          in_mag = data_in[DATA_IN_W-1:0];
        else if (neg[DATA_IN_W])
          in_mag = '1;
        else
          in_mag = neg[DATA_IN_W-1:0];
      end
    end else begin : g_unsigned
      always_comb begin
        in_sign = 1'b0;
        in_mag  = data_in;
      end
    end
  endgenerate

  // Ascending scan: the last hit is the highest set bit at or above B+1.
  always_comb begin
    seg_exp  = '0;
    seg_mant = s1_mag_q[B -: MANT_W];
    for (int i = B + 1; i < DATA_IN_W; i++) begin
      if (s1_mag_q[i]) begin
        seg_exp  = EXP_W'(i - B);
        seg_mant = s1_mag_q[i - 1 -: MANT_W];
      end
    end
  end

  always_comb begin
    code = '0;
    code[EXP_W+MANT_W-1:0] = {seg_exp, seg_mant};
    if (SIGNED != 0)
      code[CODE_W-1] = s1_sign_q;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_mag_d    = s1_mag_q;
    s1_tag_d    = s1_tag_q;
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    tag_out_d   = tag_out_q;
    if (!stall) begin
      s1_valid_d  = valid_in;
      s1_sign_d   = in_sign;
      s1_mag_d    = in_mag;
      s1_tag_d    = tag_in;
      valid_out_d = s1_valid_q;
      data_out_d  = code ^ XOR_MASK;
      tag_out_d   = s1_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_tag_q    <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      tag_out_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      s1_tag_q    <= s1_tag_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      tag_out_q   <= tag_out_d;
    end
  end

endmodule

// File: tb/tb_alaw_coder_pipe.sv
// Bench for alaw_coder_pipe: default, G.711 and two sweep configurations
// checked against an arithmetic A-law reference model.
module tb_alaw_coder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int n_pass = 0;
  int n_total = 0;

  logic [14:0] d_data_in;
  logic [3:0]  d_tag_in, d_tag_out;
  logic        d_valid_in, d_ready_in, d_valid_out, d_ready_out;
  logic [7:0]  d_data_out;

  logic [12:0] g_data_in;
  logic [3:0]  g_tag_in, g_tag_out;
  logic        g_valid_in, g_ready_in, g_valid_out, g_ready_out;
  logic [7:0]  g_data_out;

  logic [7:0]  a_data_in;
  logic [3:0]  a_tag_in, a_tag_out;
  logic        a_valid_in, a_ready_in, a_valid_out, a_ready_out;
  logic [5:0]  a_data_out;

  logic [15:0] b_data_in;
  logic [3:0]  b_tag_in, b_tag_out;
  logic        b_valid_in, b_ready_in, b_valid_out, b_ready_out;
  logic [7:0]  b_data_out;

  alaw_coder_pipe u_def (
    .clk(clk), .rst(rst), .data_in(d_data_in), .tag_in(d_tag_in), .valid_in(d_valid_in),
    .ready_in(d_ready_in), .data_out(d_data_out), .tag_out(d_tag_out),
    .valid_out(d_valid_out), .ready_out(d_ready_out));

  alaw_coder_pipe #(.DATA_IN_W(12), .EXP_W(3), .MANT_W(4), .SIGNED(1), .XOR_MASK(8'hD5)) u_g711 (
    .clk(clk), .rst(rst), .data_in(g_data_in), .tag_in(g_tag_in), .valid_in(g_valid_in),
    .ready_in(g_ready_in), .data_out(g_data_out), .tag_out(g_tag_out),
    .valid_out(g_valid_out), .ready_out(g_ready_out));

  alaw_coder_pipe #(.DATA_IN_W(8), .EXP_W(2), .MANT_W(4)) u_sw_a (
    .clk(clk), .rst(rst), .data_in(a_data_in), .tag_in(a_tag_in), .valid_in(a_valid_in),
    .ready_in(a_ready_in), .data_out(a_data_out), .tag_out(a_tag_out),
    .valid_out(a_valid_out), .ready_out(a_ready_out));

  alaw_coder_pipe #(.DATA_IN_W(16), .EXP_W(3), .MANT_W(5)) u_sw_b (
    .clk(clk), .rst(rst), .data_in(b_data_in), .tag_in(b_tag_in), .valid_in(b_valid_in),
    .ready_in(b_ready_in), .data_out(b_data_out), .tag_out(b_tag_out),
    .valid_out(b_valid_out), .ready_out(b_ready_out));

  // Reference: sign/magnitude, floor(log2) segment search, shift-and-mask mantissa.
  function automatic int ref_code(int dw, int ew, int mw, int sg, int mask, int raw);
    int b, mag, p, e, m, s;
    b = dw - (1 << ew);
    s = 0;
    mag = raw;
    if (sg != 0 && raw >= (1 << dw)) begin
      s = 1;
      mag = (1 << (dw + 1)) - raw;
      if (mag > (1 << dw) - 1) mag = (1 << dw) - 1;
    end
    p = 0;
    while ((1 << (p + 1)) <= mag) p++;
    if (mag < (1 << (b + 1))) begin
      e = 0;
      m = (mag >> (b + 1 - mw)) % (1 << mw);
    end else begin
      e = p - b;
      m = (mag >> (p - mw)) % (1 << mw);
    end
    return ((s << (ew + mw)) | (e << mw) | m) ^ mask;
  endfunction

  logic [14:0] vec_in  [6];
  logic [7:0]  vec_exp [6];
  int          exp_code[300];
  int          exp_vld [300];

  task automatic idle(int n);
    d_valid_in = 0; g_valid_in = 0; a_valid_in = 0; b_valid_in = 0;
    d_ready_out = 1; g_ready_out = 1; a_ready_out = 1; b_ready_out = 1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    d_ready_out = 0;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (d_valid_out !== 1'b0) $display("[TB] FAIL reset_valid_out: got %b want 0", d_valid_out); else n_pass++;
    n_total++; if (d_data_out !== 8'h00) $display("[TB] FAIL reset_data_out: got %h want 00", d_data_out); else n_pass++;
    n_total++; if (d_tag_out !== 4'h0) $display("[TB] FAIL reset_tag_out: got %h want 0", d_tag_out); else n_pass++;
    rst = 0;
    @(negedge clk);
    #1;
    n_total++; if (d_ready_in !== 1'b1) $display("[TB] FAIL reset_ready_in: got %b want 1", d_ready_in); else n_pass++;
    idle(2);
  endtask

  task automatic test_vectors();
    d_ready_out = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 6) begin
        d_valid_in = 1; d_data_in = vec_in[c]; d_tag_in = 4'(c);
      end else d_valid_in = 0;
      #1;
      if (c >= 2) begin
        n_total++; if (d_valid_out !== 1'b1) $display("[TB] FAIL vec_valid[%0d]: got %b want 1", c - 2, d_valid_out); else n_pass++;
        n_total++; if (d_data_out !== vec_exp[c-2]) $display("[TB] FAIL vec_data[%0d]: got %h want %h", c - 2, d_data_out, vec_exp[c-2]); else n_pass++;
        n_total++; if (d_tag_out !== 4'(c - 2)) $display("[TB] FAIL vec_tag[%0d]: got %h want %h", c - 2, d_tag_out, 4'(c - 2)); else n_pass++;
      end else begin
        n_total++; if (d_valid_out !== 1'b0) $display("[TB] FAIL vec_latency[%0d]: got %b want 0", c, d_valid_out); else n_pass++;
      end
    end
    idle(3);
  endtask

  task automatic test_bubbles();
    d_ready_out = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      d_valid_in = (c < 6) && (c % 2 == 0);
      d_data_in  = 15'($urandom_range(0, 32767));
      d_tag_in   = 4'(c + 7);
      exp_vld[c]  = int'(d_valid_in);
      exp_code[c] = ref_code(15, 3, 5, 0, 0, int'(d_data_in));
      #1;
      if (c >= 2) begin
        n_total++; if (d_valid_out !== exp_vld[c-2][0]) $display("[TB] FAIL bubble_valid[%0d]: got %b want %0d", c, d_valid_out, exp_vld[c-2]); else n_pass++;
        if (exp_vld[c-2] != 0) begin
          n_total++; if (d_data_out !== 8'(exp_code[c-2])) $display("[TB] FAIL bubble_data[%0d]: got %h want %h", c, d_data_out, 8'(exp_code[c-2])); else n_pass++;
          n_total++; if (d_tag_out !== 4'(c + 5)) $display("[TB] FAIL bubble_tag[%0d]: got %h want %h", c, d_tag_out, 4'(c + 5)); else n_pass++;
        end
      end
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  q_code[$];
    logic [3:0]  q_tag[$];
    logic [14:0] cur;
    logic        prev_stall, prev_valid;
    logic [7:0]  prev_data, exp_d;
    logic [3:0]  prev_tag, exp_t;
    int sent, recv;
    sent = 0; recv = 0; prev_stall = 0; prev_valid = 0; prev_data = 0; prev_tag = 0;
    cur = 15'($urandom_range(0, 32767));
    for (int c = 0; c < 400 && recv < 20; c++) begin
      @(negedge clk);
      d_ready_out = 1'($urandom_range(0, 1));
      d_valid_in  = (sent < 20);
      d_data_in   = cur;
      d_tag_in    = 4'(sent);
      #1;
      n_total++; if (d_ready_in !== ~(d_valid_out & ~d_ready_out)) $display("[TB] FAIL bp_ready_in[%0d]: got %b want %b", c, d_ready_in, ~(d_valid_out & ~d_ready_out)); else n_pass++;
      if (prev_stall) begin
        n_total++;
        if (d_valid_out !== prev_valid || d_data_out !== prev_data || d_tag_out !== prev_tag)
          $display("[TB] FAIL bp_hold[%0d]: got %b/%h/%h want %b/%h/%h", c, d_valid_out, d_data_out, d_tag_out, prev_valid, prev_data, prev_tag);
        else n_pass++;
      end
      if (d_valid_out && d_ready_out) begin
        n_total++;
        if (q_code.size() == 0) $display("[TB] FAIL bp_extra[%0d]: got %h with nothing outstanding want none", c, d_data_out);
        else begin
          exp_d = q_code.pop_front();
          exp_t = q_tag.pop_front();
          if (d_data_out !== exp_d || d_tag_out !== exp_t)
            $display("[TB] FAIL bp_order[%0d]: got %h/%h want %h/%h", recv, d_data_out, d_tag_out, exp_d, exp_t);
          else n_pass++;
        end
        recv++;
      end
      if (d_valid_in && d_ready_in) begin
        q_code.push_back(8'(ref_code(15, 3, 5, 0, 0, int'(cur))));
        q_tag.push_back(4'(sent));
        sent++;
        cur = 15'($urandom_range(0, 32767));
      end
      prev_stall = d_valid_out & ~d_ready_out;
      prev_valid = d_valid_out; prev_data = d_data_out; prev_tag = d_tag_out;
    end
    n_total++; if (recv != 20) $display("[TB] FAIL bp_received: got %0d want 20", recv); else n_pass++;
    n_total++; if (q_code.size() != 0) $display("[TB] FAIL bp_lost: got %0d outstanding want 0", q_code.size()); else n_pass++;
    idle(3);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_ready_out = 0; d_valid_in = 1; d_data_in = 15'h4000; d_tag_in = 4'hA;
    @(negedge clk);
    d_data_in = 15'h7FFF; d_tag_in = 4'hB;
    @(negedge clk);
    d_valid_in = 0;
    #1;
    n_total++; if (d_valid_out !== 1'b1 || d_data_out !== 8'hE0) $display("[TB] FAIL rmid_preload: got %b/%h want 1/e0", d_valid_out, d_data_out); else n_pass++;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; d_valid_in = 1; d_data_in = 15'h0A50; d_tag_in = 4'h3;
    #1;
    n_total++; if (d_valid_out !== 1'b0) $display("[TB] FAIL rmid_valid: got %b want 0", d_valid_out); else n_pass++;
    n_total++; if (d_data_out !== 8'h00) $display("[TB] FAIL rmid_data: got %h want 00", d_data_out); else n_pass++;
    n_total++; if (d_tag_out !== 4'h0) $display("[TB] FAIL rmid_tag: got %h want 0", d_tag_out); else n_pass++;
    n_total++; if (d_ready_in !== 1'b1) $display("[TB] FAIL rmid_ready_in: got %b want 1", d_ready_in); else n_pass++;
    @(negedge clk);
    d_valid_in = 0; d_ready_out = 1;
    #1;
    n_total++; if (d_valid_out !== 1'b0) $display("[TB] FAIL rmid_flushed: got %b want 0", d_valid_out); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (d_valid_out !== 1'b1 || d_data_out !== 8'h89 || d_tag_out !== 4'h3) $display("[TB] FAIL rmid_next: got %b/%h/%h want 1/89/3", d_valid_out, d_data_out, d_tag_out); else n_pass++;
    idle(3);
  endtask

  task automatic test_g711();
    logic [12:0] gin[4];
    logic [7:0]  gexp[4];
    gin[0] = 13'h0000; gin[1] = 13'h1000; gin[2] = 13'h0FFF; gin[3] = 13'h1FFF;
    gexp[0] = 8'hD5; gexp[1] = 8'h2A; gexp[2] = 8'hAA; gexp[3] = 8'h55;
    g_ready_out = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      g_valid_in = (c < 4);
      if (c < 4) begin g_data_in = gin[c]; g_tag_in = 4'(c + 1); end
      #1;
      if (c >= 2) begin
        n_total++; if (g_valid_out !== 1'b1 || g_data_out !== gexp[c-2] || g_tag_out !== 4'(c - 1))
          $display("[TB] FAIL g711_vec[%0d]: got %b/%h/%h want 1/%h/%h", c - 2, g_valid_out, g_data_out, g_tag_out, gexp[c-2], 4'(c - 1));
        else n_pass++;
      end
    end
    for (int c = 0; c < 66; c++) begin
      @(negedge clk);
      g_valid_in = (c < 64);
      g_data_in  = 13'($urandom_range(0, 8191));
      g_tag_in   = 4'(c);
      exp_code[c] = ref_code(12, 3, 4, 1, 8'hD5, int'(g_data_in));
      #1;
      if (c >= 2) begin
        n_total++; if (g_valid_out !== 1'b1 || g_data_out !== 8'(exp_code[c-2]) || g_tag_out !== 4'(c - 2))
          $display("[TB] FAIL g711_rand[%0d]: got %b/%h/%h want 1/%h/%h", c - 2, g_valid_out, g_data_out, g_tag_out, 8'(exp_code[c-2]), 4'(c - 2));
        else n_pass++;
      end
    end
    idle(3);
  endtask

  task automatic test_sweep();
    a_ready_out = 1;
    for (int c = 0; c < 258; c++) begin
      @(negedge clk);
      a_valid_in = (c < 256);
      a_data_in  = 8'(c);
      a_tag_in   = 4'(c);
      exp_code[c] = ref_code(8, 2, 4, 0, 0, c);
      #1;
      if (c >= 2) begin
        n_total++; if (a_valid_out !== 1'b1 || a_data_out !== 6'(exp_code[c-2]) || a_tag_out !== 4'(c - 2))
          $display("[TB] FAIL sweep_a[%0d]: got %b/%h/%h want 1/%h/%h", c - 2, a_valid_out, a_data_out, a_tag_out, 6'(exp_code[c-2]), 4'(c - 2));
        else n_pass++;
      end
    end
    b_ready_out = 1;
    for (int c = 0; c < 202; c++) begin
      @(negedge clk);
      b_valid_in = (c < 200);
      b_data_in  = (c % 4 == 0) ? 16'(1 << (c % 16)) : 16'($urandom_range(0, 65535));
      b_tag_in   = 4'(c);
      exp_code[c] = ref_code(16, 3, 5, 0, 0, int'(b_data_in));
      #1;
      if (c >= 2) begin
        n_total++; if (b_valid_out !== 1'b1 || b_data_out !== 8'(exp_code[c-2]) || b_tag_out !== 4'(c - 2))
          $display("[TB] FAIL sweep_b[%0d]: got %b/%h/%h want 1/%h/%h", c - 2, b_valid_out, b_data_out, b_tag_out, 8'(exp_code[c-2]), 4'(c - 2));
        else n_pass++;
      end
    end
    idle(3);
  endtask

  initial begin
    rst = 1;
    d_data_in = '0; d_tag_in = '0; d_valid_in = 0; d_ready_out = 0;
    g_data_in = '0; g_tag_in = '0; g_valid_in = 0; g_ready_out = 1;
    a_data_in = '0; a_tag_in = '0; a_valid_in = 0; a_ready_out = 1;
    b_data_in = '0; b_tag_in = '0; b_valid_in = 0; b_ready_out = 1;
    vec_in[0] = 15'h0000; vec_in[1] = 15'h00F8; vec_in[2] = 15'h0100;
    vec_in[3] = 15'h0A50; vec_in[4] = 15'h4000; vec_in[5] = 15'h7FFF;
    vec_exp[0] = 8'h00; vec_exp[1] = 8'h1F; vec_exp[2] = 8'h20;
    vec_exp[3] = 8'h89; vec_exp[4] = 8'hE0; vec_exp[5] = 8'hFF;
    test_reset();
    test_vectors();
    test_bubbles();
    test_back_to_back();
    test_reset_mid();
    test_g711();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
